// File: rtl/serial_fulladder_seq_if.sv
`timescale 1ns/1ps
// Operand/result handshake bundle for the bit-serial adder stage.
// The producer/consumer side uses master; the adder itself uses slave.
interface serial_fulladder_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output busy
  );
endinterface

// File: rtl/serial_fulladder_seq.sv
`timescale 1ns/1ps
// Bit-serial adder: one full-adder cell evaluated per clock, LSB first,
// with a registered carry. Operands accepted on IDLE, result held in DONE.
module serial_fulladder_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  serial_fulladder_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic               s_bit;
  logic               carry_nxt;

  assign s_bit     = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
  assign carry_nxt = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at sum[0].
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        carry_d           = carry_nxt;
        sum_d             = sum_q >> 1;
        sum_d[WIDTH-1]    = s_bit;
        cnt_d             = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = carry_nxt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush wins over any handshake on the same edge.
    if (clr) begin
      state_d = S_IDLE;
      a_sh_d  = '0;
      b_sh_d  = '0;
      carry_d = 1'b0;
      cnt_d   = '0;
      sum_d   = '0;
      cout_d  = 1'b0;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_fulladder_seq.sv
`timescale 1ns/1ps
// Bench for serial_fulladder_seq: WIDTH=8 and WIDTH=1 instances, a
// timeline-based reference model, and directed plus random operations.
module tb_serial_fulladder_seq;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  logic clr1  = 1'b0;

  always #5 clk = ~clk;

  serial_fulladder_seq_if #(.WIDTH(W)) bus8 ();
  serial_fulladder_seq_if #(.WIDTH(1)) bus1 ();

  serial_fulladder_seq #(.WIDTH(W)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus8.slave)
  );

  serial_fulladder_seq #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr1),
    .bus   (bus1.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: an operation is live from its accept edge until the edge on
  // which the result is taken; the result is visible from W edges after accept.
  logic        m_active = 1'b0;
  int unsigned cyc      = 0;
  int unsigned m_acc    = 0;
  logic [W:0]  m_exp    = '0;
  logic        m_ov_before;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
    end else begin
      m_ov_before = m_active && ((cyc - m_acc) >= W);
      cyc++;
      if (clr) begin
        m_active = 1'b0;
      end else if (!m_active && bus8.in_valid) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_exp    = {1'b0, bus8.a} + {1'b0, bus8.b} + (W+1)'(bus8.cin);
      end else if (m_ov_before && bus8.out_ready) begin
        m_active = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    logic ev;
    ev = m_active && ((cyc - m_acc) >= W);
    chk("mdl_in_ready", bus8.in_ready, !m_active);
    chk("mdl_out_valid", bus8.out_valid, ev);
    chk("mdl_busy", bus8.busy, m_active && !ev);
    if (ev) begin
      chk("mdl_sum", bus8.sum, m_exp[W-1:0]);
      chk("mdl_cout", bus8.cout, m_exp[W]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation (must be called in IDLE, #1 after an edge) and wait
  // for the result. With hold=1 the result is left pending in DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [8:0] exp, input string nm, input bit hold);
    int n;
    bus8.in_valid  = 1'b1;
    bus8.a         = a;
    bus8.b         = b;
    bus8.cin       = c;
    bus8.out_ready = !hold;
    step();
    bus8.in_valid = 1'b0;
    bus8.a        = 8'($urandom);
    bus8.b        = 8'($urandom);
    bus8.cin      = 1'($urandom);
    chk({nm, "_in_ready_low"}, bus8.in_ready, 1'b0);
    n = 0;
    while (!bus8.out_valid && n < 64) begin
      step();
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_sum"}, bus8.sum, exp[7:0]);
    chk({nm, "_cout"}, bus8.cout, exp[8]);
    if (!hold) begin
      step();
      chk({nm, "_in_ready_back"}, bus8.in_ready, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         n;

    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus8.in_ready, 1'b1);
    chk("rst_out_valid", bus8.out_valid, 1'b0);
    chk("rst_busy", bus8.busy, 1'b0);
    chk("rst_sum", bus8.sum, 8'h00);
    chk("rst_cout", bus8.cout, 1'b0);
    rst_n = 1'b1;
    step();

    // WIDTH=1 exhaustive
    for (int v = 0; v < 8; v++) begin
      bus1.a        = v[2];
      bus1.b        = v[1];
      bus1.cin      = v[0];
      bus1.in_valid = 1'b1;
      step();
      bus1.in_valid = 1'b0;
      n = 0;
      while (!bus1.out_valid && n < 8) begin
        step();
        n++;
      end
      chk("w1_latency", n, 1);
      chk("w1_result", {bus1.cout, bus1.sum}, 2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      step();
      chk("w1_in_ready_back", bus1.in_ready, 1'b1);
    end

    run8(8'h5A, 8'h33, 1'b0, 9'h08D, "t_5a_33", 1'b0);
    chk("model_pin_5a_33", m_exp, 9'h08D);
    run8(8'hFF, 8'h01, 1'b0, 9'h100, "t_ff_01", 1'b0);
    run8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "t_ff_ff_1", 1'b0);
    chk("model_pin_ff_ff_1", m_exp, 9'h1FF);
    run8(8'h00, 8'h00, 1'b1, 9'h001, "t_00_00_1", 1'b0);

    // Backpressure with new operands offered while the result is pending
    run8(8'h5A, 8'h33, 1'b0, 9'h08D, "bp", 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = (i % 2 == 0);
      bus8.a        = 8'($urandom);
      bus8.b        = 8'($urandom);
      step();
      chk("bp_sum_stable", bus8.sum, 8'h8D);
      chk("bp_cout_stable", bus8.cout, 1'b0);
      chk("bp_out_valid", bus8.out_valid, 1'b1);
      chk("bp_in_ready", bus8.in_ready, 1'b0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", bus8.in_ready, 1'b1);
    chk("bp_release_out_valid", bus8.out_valid, 1'b0);
    run8(8'h12, 8'h34, 1'b1, 9'h047, "bp_next", 1'b0);

    // Asynchronous reset in the middle of a run
    bus8.in_valid = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0;
    step();
    bus8.in_valid = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus8.out_valid, 1'b0);
    chk("mid_rst_busy", bus8.busy, 1'b0);
    chk("mid_rst_in_ready", bus8.in_ready, 1'b1);
    chk("mid_rst_sum", bus8.sum, 8'h00);
    chk("mid_rst_cout", bus8.cout, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    chk("post_rst_in_ready", bus8.in_ready, 1'b1);
    step();
    run8(8'h10, 8'h20, 1'b0, 9'h030, "post_rst", 1'b0);

    // Flush while the result is being taken
    run8(8'h5A, 8'h33, 1'b0, 9'h08D, "clr_done", 1'b1);
    bus8.out_ready = 1'b1;
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_done_out_valid", bus8.out_valid, 1'b0);
    chk("clr_done_sum", bus8.sum, 8'h00);
    chk("clr_done_in_ready", bus8.in_ready, 1'b1);

    // Flush beats an acceptance
    clr = 1'b1; bus8.in_valid = 1'b1; bus8.a = 8'h01; bus8.b = 8'h02; bus8.cin = 1'b0;
    step();
    clr = 1'b0; bus8.in_valid = 1'b0;
    chk("clr_idle_busy", bus8.busy, 1'b0);
    chk("clr_idle_in_ready", bus8.in_ready, 1'b1);
    step();
    chk("clr_idle_busy_later", bus8.busy, 1'b0);
    chk("clr_idle_out_valid", bus8.out_valid, 1'b0);

    // Random regression with occasional backpressure
    for (int i = 0; i < 1000; i++) begin
      bit hold;
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rc   = 1'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      run8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + 9'(rc), "rand", hold);
      if (hold) begin
        repeat ($urandom_range(1, 4)) step();
        bus8.out_ready = 1'b1;
        step();
        chk("rand_hold_in_ready", bus8.in_ready, 1'b1);
      end
    end

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_fulladder_seq.md
Name: serial_fulladder_seq

Overview:
- Bit-serial adder stage that drives a single full-adder cell one bit per clock.
- Operands are taken in parallel on a valid/ready handshake and shifted LSB-first through the sum/carry logic, with a registered carry between bits.
- The WIDTH-bit sum and the final carry-out are presented on a valid/ready output port.
- Sits directly upstream of consumers of multi-bit sums; gives formal checks a sequential counterpart to the combinational adder cells.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous flush to IDLE; priority over all other inputs except rst_n
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  block accepts operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum/cout valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of bit WIDTH-1
- busy  output  1  high in RUN

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - Shift registers, carry register, counter, sum and cout all 0.
  - in_ready=1, out_valid=0, busy=0.
- Reset takes effect mid-operation with no completion and no partial output.
- State machine: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load a_sh=a, b_sh=b, carry=cin, cnt=0, clear sum register, clear cout.
  - Then go to RUN.
- RUN (busy=1, in_ready=0), on each edge:
  - s = a_sh[0]^b_sh[0]^carry
  - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]))
  - sum register shifts right with s inserted at bit WIDTH-1
  - a_sh and b_sh shift right with 0 filled
  - cnt <= cnt+1
  - On the edge where cnt==WIDTH-1: cout <= new carry, go to DONE.
- DONE (out_valid=1, in_ready=0):
  - sum and cout held stable until out_ready=1.
  - On out_valid&out_ready, go to IDLE on that edge.
  - out_valid drops in the next cycle.
- Latency: acceptance edge E0; out_valid rises exactly WIDTH edges later, after E_WIDTH.
- Throughput: one operation per WIDTH+2 cycles minimum when out_ready is held high.
- No overlap: in_valid is ignored outside IDLE; a, b and cin may change freely after acceptance.
- Backpressure: out_ready low in DONE holds the state indefinitely; sum and cout do not change.
- clr=1:
  - Next edge forces IDLE, clears all registers as reset, out_valid=0.
  - Beats a simultaneous in_valid acceptance or out_ready completion.
- sum/cout outside DONE: sum shows the partial shift contents during RUN; consumers use them only when out_valid=1.
- Counter width: ceil(log2(WIDTH+1)) bits. No wrap beyond WIDTH-1 in RUN.
- WIDTH=1: RUN lasts exactly one edge; sum[0]=a^b^cin, cout=majority(a,b,cin).
- Arithmetic: {cout,sum} == a+b+cin exactly, modulo 2^(WIDTH+1).
- Outputs in_ready, out_valid and busy are decoded from registered state only; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=8; a=0x5A, b=0x33, cin=0, out_ready=1 -> out_valid high 8 edges after accept; sum=0x8D, cout=0; in_ready back to 1 one cycle after handshake.
- WIDTH=8; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0, b=0, cin=1 -> sum=0x01, cout=0.
- Backpressure: after the 0x5A+0x33 result, hold out_ready=0 for 5 cycles while toggling in_valid with new operands -> sum=0x8D and out_valid stay stable, in_ready=0, no second accept. Raise out_ready -> IDLE next cycle; the next in_valid is accepted.
- Reset mid-run: deassert rst_n after the 3rd RUN edge of 0xAA+0x55 -> all outputs 0 immediately, in_ready=1 on release. A fresh 0x10+0x20 then yields sum=0x30, cout=0.
- clr: assert clr in DONE with out_ready=1 -> IDLE next edge, out_valid=0, sum=0. Assert clr together with in_valid in IDLE -> no accept; busy stays 0.
- WIDTH=1 build: all 8 (a,b,cin) combinations -> out_valid one edge after accept; {cout,sum} equals a+b+cin. Random WIDTH=8 regression of 1000 ops checked against a+b+cin.
